// File: rtl/xy_out_port_ctrl.sv
// Output-port stage of the mesh XY switch: locks onto the arbiter's pick for a
// whole packet and forwards its flits through one registered valid/ready slot.
module xy_out_port_ctrl #(
  parameter int PORT_N = 5,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [$clog2(PORT_N)-1:0]  arb_sel_i,
  input  logic [PORT_N-1:0]          in_vld_i,
  input  logic [PORT_N-1:0]          in_last_i,
  input  logic [PORT_N*DATA_W-1:0]   in_data_i,
  output logic [PORT_N-1:0]          in_rdy_o,
  output logic                       out_vld_o,
  output logic                       out_last_o,
  output logic [DATA_W-1:0]          out_data_o,
  input  logic                       out_rdy_i,
  output logic                       lock_o,
  output logic [$clog2(PORT_N)-1:0]  sel_o,
  output logic [CNT_W-1:0]           pkt_cnt_o
);
  localparam int SEL_W = $clog2(PORT_N);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                        state;
  logic [SEL_W-1:0]              sel_q;
  logic [PORT_N-1:0][DATA_W-1:0] in_data;
  logic                          space;
  logic                          accept;
  logic                          req_ok;

  assign in_data = in_data_i;

  // Slot is free when empty or being drained this cycle.
  assign space  = !out_vld_o || out_rdy_i;
  assign accept = (state == LOCKED) && in_vld_i[sel_q] && space;
  // Out-of-range selects are rejected before the valid bit is consulted.
  assign req_ok = (|in_vld_i) && (32'(arb_sel_i) < 32'(PORT_N)) && in_vld_i[arb_sel_i];

  assign lock_o = (state == LOCKED);
  assign sel_o  = sel_q;

  always_comb begin
    in_rdy_o = '0;
    if (state == LOCKED) in_rdy_o[sel_q] = space;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      sel_q     <= '0;
      pkt_cnt_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_ok) begin
            sel_q <= arb_sel_i;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          // Only the tail accept releases the lock; other requesters wait.
          if (accept && in_last_i[sel_q]) begin
            state     <= IDLE;
            pkt_cnt_o <= pkt_cnt_o + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_vld_o  <= 1'b0;
      out_last_o <= 1'b0;
      out_data_o <= '0;
    end else if (accept) begin
      out_vld_o  <= 1'b1;
      out_last_o <= in_last_i[sel_q];
      out_data_o <= in_data[sel_q];
    end else if (out_vld_o && out_rdy_i) begin
      out_vld_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xy_out_port_ctrl.sv
// Bench for xy_out_port_ctrl: directed scenarios plus a randomized run checked
// against a packet-level model built around an output-slot queue.
module tb_xy_out_port_ctrl;
  localparam int PN = 5;
  localparam int DW = 8;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [2:0]        arb_sel = '0;
  logic [PN-1:0]     in_vld = '0;
  logic [PN-1:0]     in_last = '0;
  logic [PN*DW-1:0]  in_data = '0;
  logic [PN-1:0]     in_rdy;
  logic              out_vld;
  logic              out_last;
  logic [DW-1:0]     out_data;
  logic              out_rdy = 1'b1;
  logic              lock;
  logic [2:0]        sel;
  logic [CW-1:0]     pkt_cnt;

  int n_chk = 0;
  int n_pass = 0;
  int exp_cnt = 0;

  xy_out_port_ctrl #(.PORT_N(PN), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .arb_sel_i(arb_sel), .in_vld_i(in_vld),
    .in_last_i(in_last), .in_data_i(in_data), .in_rdy_o(in_rdy),
    .out_vld_o(out_vld), .out_last_o(out_last), .out_data_o(out_data),
    .out_rdy_i(out_rdy), .lock_o(lock), .sel_o(sel), .pkt_cnt_o(pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_flit(input int k, input logic [DW-1:0] d, input logic l);
    in_data[k*DW +: DW] = d;
    in_last[k] = l;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_vld = '0; in_last = '0; in_data = '0; arb_sel = '0; out_rdy = 1'b1;
    step(); step();
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; #3;
    n_chk++; if (out_vld !== 1'b0) $display("FAIL reset_out_vld got=%b exp=0", out_vld); else n_pass++;
    n_chk++; if (out_last !== 1'b0) $display("FAIL reset_out_last got=%b exp=0", out_last); else n_pass++;
    n_chk++; if (out_data !== 8'h00) $display("FAIL reset_out_data got=%h exp=00", out_data); else n_pass++;
    n_chk++; if (pkt_cnt !== 4'h0) $display("FAIL reset_pkt_cnt got=%h exp=0", pkt_cnt); else n_pass++;
    n_chk++; if (lock !== 1'b0) $display("FAIL reset_lock got=%b exp=0", lock); else n_pass++;
    n_chk++; if (in_rdy !== 5'b0) $display("FAIL reset_in_rdy got=%b exp=00000", in_rdy); else n_pass++;
    n_chk++; if (sel !== 3'd0) $display("FAIL reset_sel got=%0d exp=0", sel); else n_pass++;
    step();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    in_vld = 5'b00100; arb_sel = 3'd2; set_flit(2, 8'hA1, 1'b0);
    step();
    n_chk++; if (lock !== 1'b1) $display("FAIL basic_lock got=%b exp=1", lock); else n_pass++;
    n_chk++; if (sel !== 3'd2) $display("FAIL basic_sel got=%0d exp=2", sel); else n_pass++;
    n_chk++; if (in_rdy !== 5'b00100) $display("FAIL basic_in_rdy got=%b exp=00100", in_rdy); else n_pass++;
    n_chk++; if (out_vld !== 1'b0) $display("FAIL basic_vld0 got=%b exp=0", out_vld); else n_pass++;
    step();
    n_chk++; if ({out_vld, out_last, out_data} !== {2'b10, 8'hA1}) $display("FAIL basic_f1 got=%b%b%h exp=10a1", out_vld, out_last, out_data); else n_pass++;
    set_flit(2, 8'hA2, 1'b0);
    step();
    n_chk++; if ({out_vld, out_last, out_data} !== {2'b10, 8'hA2}) $display("FAIL basic_f2 got=%b%b%h exp=10a2", out_vld, out_last, out_data); else n_pass++;
    set_flit(2, 8'hA3, 1'b1);
    step(); exp_cnt++;
    n_chk++; if ({out_vld, out_last, out_data} !== {2'b11, 8'hA3}) $display("FAIL basic_f3 got=%b%b%h exp=11a3", out_vld, out_last, out_data); else n_pass++;
    n_chk++; if (pkt_cnt !== 4'(exp_cnt)) $display("FAIL basic_cnt got=%0d exp=%0d", pkt_cnt, exp_cnt); else n_pass++;
    n_chk++; if (lock !== 1'b0) $display("FAIL basic_unlock got=%b exp=0", lock); else n_pass++;
    in_vld = '0;
    step();
    n_chk++; if (out_vld !== 1'b0) $display("FAIL basic_drain got=%b exp=0", out_vld); else n_pass++;
  endtask

  task automatic test_preempt();
    do_reset();
    in_vld = 5'b00010; arb_sel = 3'd1; set_flit(1, 8'h10, 1'b0);
    step(); step();
    n_chk++; if (out_data !== 8'h10) $display("FAIL pre_f1 got=%h exp=10", out_data); else n_pass++;
    in_vld = 5'b10010; arb_sel = 3'd4; set_flit(4, 8'h40, 1'b1); set_flit(1, 8'h11, 1'b0);
    #1;
    n_chk++; if (in_rdy !== 5'b00010) $display("FAIL pre_rdy_a got=%b exp=00010", in_rdy); else n_pass++;
    step();
    n_chk++; if (out_data !== 8'h11) $display("FAIL pre_f2 got=%h exp=11", out_data); else n_pass++;
    n_chk++; if (in_rdy !== 5'b00010) $display("FAIL pre_rdy_b got=%b exp=00010", in_rdy); else n_pass++;
    n_chk++; if (sel !== 3'd1) $display("FAIL pre_sel got=%0d exp=1", sel); else n_pass++;
    set_flit(1, 8'h12, 1'b1);
    step(); exp_cnt++;
    n_chk++; if ({out_last, out_data} !== {1'b1, 8'h12}) $display("FAIL pre_tail got=%b%h exp=112", out_last, out_data); else n_pass++;
    n_chk++; if ({lock, in_rdy} !== 6'b0) $display("FAIL pre_idle got=%b%b exp=000000", lock, in_rdy); else n_pass++;
    in_vld = 5'b10000;
    step();
    n_chk++; if ({lock, sel, in_rdy} !== {1'b1, 3'd4, 5'b10000}) $display("FAIL pre_relock got=%b/%0d/%b exp=1/4/10000", lock, sel, in_rdy); else n_pass++;
    n_chk++; if (out_vld !== 1'b0) $display("FAIL pre_gap got=%b exp=0", out_vld); else n_pass++;
    step(); exp_cnt++;
    n_chk++; if ({out_vld, out_last, out_data} !== {2'b11, 8'h40}) $display("FAIL pre_p4 got=%b%b%h exp=1140", out_vld, out_last, out_data); else n_pass++;
    n_chk++; if (pkt_cnt !== 4'(exp_cnt)) $display("FAIL pre_cnt got=%0d exp=%0d", pkt_cnt, exp_cnt); else n_pass++;
    in_vld = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    in_vld = 5'b01000; arb_sel = 3'd3; set_flit(3, 8'h5C, 1'b0);
    step(); step();
    out_rdy = 1'b0; set_flit(3, 8'h5D, 1'b1);
    #1;
    n_chk++; if (in_rdy !== 5'b0) $display("FAIL bp_rdy0 got=%b exp=00000", in_rdy); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if ({out_vld, out_data, in_rdy, lock} !== {1'b1, 8'h5C, 5'b0, 1'b1}) $display("FAIL bp_hold%0d got=%b/%h/%b/%b exp=1/5c/00000/1", i, out_vld, out_data, in_rdy, lock); else n_pass++;
    end
    out_rdy = 1'b1; #1;
    n_chk++; if (in_rdy !== 5'b01000) $display("FAIL bp_rdy1 got=%b exp=01000", in_rdy); else n_pass++;
    step(); exp_cnt++;
    n_chk++; if ({out_vld, out_last, out_data} !== {2'b11, 8'h5D}) $display("FAIL bp_next got=%b%b%h exp=115d", out_vld, out_last, out_data); else n_pass++;
    n_chk++; if (pkt_cnt !== 4'(exp_cnt)) $display("FAIL bp_cnt got=%0d exp=%0d", pkt_cnt, exp_cnt); else n_pass++;
    in_vld = '0;
    step();
    n_chk++; if (out_vld !== 1'b0) $display("FAIL bp_drain got=%b exp=0", out_vld); else n_pass++;
  endtask

  task automatic test_single_flit();
    do_reset();
    in_vld = 5'b00001; arb_sel = 3'd0;
    for (int i = 0; i < 4; i++) begin
      set_flit(0, 8'(8'h30 + i), 1'b1);
      step();
      n_chk++; if ({lock, out_vld} !== 2'b10) $display("FAIL sf_lock%0d got=%b%b exp=10", i, lock, out_vld); else n_pass++;
      step(); exp_cnt++;
      n_chk++; if ({out_vld, out_last, out_data, lock} !== {2'b11, 8'(8'h30 + i), 1'b0}) $display("FAIL sf_flit%0d got=%b%b%h%b exp=11%h0", i, out_vld, out_last, out_data, lock, 8'(8'h30 + i)); else n_pass++;
      n_chk++; if (pkt_cnt !== 4'(exp_cnt)) $display("FAIL sf_cnt%0d got=%0d exp=%0d", i, pkt_cnt, exp_cnt); else n_pass++;
    end
    in_vld = '0;
  endtask

  task automatic test_bad_sel_wrap();
    do_reset();
    in_vld = 5'b00001; arb_sel = 3'd3;
    step(); step(); step();
    n_chk++; if ({lock, in_rdy} !== 6'b0) $display("FAIL bad_nv got=%b%b exp=000000", lock, in_rdy); else n_pass++;
    in_vld = 5'b11111; arb_sel = 3'd7;
    step(); step();
    n_chk++; if ({lock, in_rdy, out_vld} !== 7'b0) $display("FAIL bad_oor got=%b%b%b exp=0000000", lock, in_rdy, out_vld); else n_pass++;
    in_vld = 5'b00001; arb_sel = 3'd0;
    for (int i = 0; i < 16; i++) begin
      set_flit(0, 8'(i), 1'b1);
      step(); step(); exp_cnt++;
      n_chk++; if (pkt_cnt !== 4'(exp_cnt)) $display("FAIL wrap_cnt%0d got=%0d exp=%0d", i, pkt_cnt, 4'(exp_cnt)); else n_pass++;
    end
    n_chk++; if (pkt_cnt !== 4'h0) $display("FAIL wrap_zero got=%0d exp=0", pkt_cnt); else n_pass++;
    in_vld = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_vld = 5'b00100; arb_sel = 3'd2; set_flit(2, 8'h77, 1'b0);
    step(); step();
    out_rdy = 1'b0;
    step();
    n_chk++; if ({out_vld, lock} !== 2'b11) $display("FAIL rm_pre got=%b%b exp=11", out_vld, lock); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_chk++; if ({out_vld, lock, in_rdy} !== 7'b0) $display("FAIL rm_async got=%b%b%b exp=0000000", out_vld, lock, in_rdy); else n_pass++;
    #1 rst = 1'b0; exp_cnt = 0;
    out_rdy = 1'b1; set_flit(2, 8'h88, 1'b0);
    step();
    n_chk++; if ({lock, sel} !== {1'b1, 3'd2}) $display("FAIL rm_relock got=%b/%0d exp=1/2", lock, sel); else n_pass++;
    step();
    n_chk++; if ({out_vld, out_last, out_data} !== {2'b10, 8'h88}) $display("FAIL rm_f1 got=%b%b%h exp=1088", out_vld, out_last, out_data); else n_pass++;
    set_flit(2, 8'h89, 1'b1);
    step(); exp_cnt++;
    n_chk++; if ({out_vld, out_last, out_data} !== {2'b11, 8'h89}) $display("FAIL rm_f2 got=%b%b%h exp=1189", out_vld, out_last, out_data); else n_pass++;
    n_chk++; if ({pkt_cnt, lock} !== {4'(exp_cnt), 1'b0}) $display("FAIL rm_done got=%0d/%b exp=%0d/0", pkt_cnt, lock, exp_cnt); else n_pass++;
    in_vld = '0;
  endtask

  task automatic test_random();
    logic [8:0]    slot[$];
    logic [PN-1:0] exp_rdy;
    bit            m_locked;
    int            m_sel;
    bit            space, acc;
    do_reset();
    m_locked = 1'b0; m_sel = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      n_chk++; if (out_vld !== (slot.size() != 0)) $display("FAIL rnd_vld c%0d got=%b exp=%b", cyc, out_vld, slot.size() != 0); else n_pass++;
      if (slot.size() != 0) begin
        n_chk++; if ({out_last, out_data} !== slot[0]) $display("FAIL rnd_flit c%0d got=%b%h exp=%b%h", cyc, out_last, out_data, slot[0][8], slot[0][7:0]); else n_pass++;
      end
      n_chk++; if (lock !== m_locked) $display("FAIL rnd_lock c%0d got=%b exp=%b", cyc, lock, m_locked); else n_pass++;
      if (m_locked) begin
        n_chk++; if (sel !== 3'(m_sel)) $display("FAIL rnd_sel c%0d got=%0d exp=%0d", cyc, sel, m_sel); else n_pass++;
      end
      n_chk++; if (pkt_cnt !== 4'(exp_cnt)) $display("FAIL rnd_cnt c%0d got=%0d exp=%0d", cyc, pkt_cnt, 4'(exp_cnt)); else n_pass++;
      in_vld = 5'($urandom);
      for (int k = 0; k < PN; k++) in_last[k] = ($urandom_range(0, 9) < 3);
      in_data = {8'($urandom), 32'($urandom)};
      arb_sel = 3'($urandom_range(0, 7));
      out_rdy = ($urandom_range(0, 3) != 0);
      #1;
      space = (slot.size() == 0) || out_rdy;
      exp_rdy = '0;
      if (m_locked && space) exp_rdy[m_sel] = 1'b1;
      n_chk++; if (in_rdy !== exp_rdy) $display("FAIL rnd_rdy c%0d got=%b exp=%b", cyc, in_rdy, exp_rdy); else n_pass++;
      acc = m_locked && in_vld[m_sel] && space;
      if (slot.size() != 0 && out_rdy) void'(slot.pop_front());
      if (acc) slot.push_back({in_last[m_sel], in_data[m_sel*DW +: DW]});
      if (m_locked) begin
        if (acc && in_last[m_sel]) begin
          m_locked = 1'b0;
          exp_cnt++;
        end
      end else if (int'(arb_sel) < PN && in_vld[arb_sel]) begin
        m_locked = 1'b1;
        m_sel = int'(arb_sel);
      end
      step();
    end
    in_vld = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_preempt();
    test_backpressure();
    test_single_flit();
    test_bad_sel_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
